// File: rtl/pio_out_pkg.sv
// Register map and status bit positions shared by the pulse-capable parallel output port.
package pio_out_pkg;
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_PLEN   = 3'd3;
  localparam logic [2:0] ADDR_PULSE  = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam int STATUS_BUSY_BIT = 0;
endpackage

// File: rtl/pio_pulse_timer.sv
// Shared pulse-length down-counter: load starts or restarts a run of i_load_val cycles.
// o_expire is a combinational strobe on the final cycle; a load on that same edge wins.
module pio_pulse_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_busy,
  output logic             o_expire
);
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  assign o_busy   = r_busy;
  assign o_expire = r_busy && (r_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= i_load_val;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/pio_out_pulse.sv
// Memory-mapped output port with DATA/SET/CLR access and timed pulses on selected bits.
// Zero-wait-state combinational reads; out_port comes straight from a register.
module pio_out_pulse
  import pio_out_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               CNT_W       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_mask;
  logic [CNT_W-1:0] r_plen;

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic             w_pulse_go;
  logic             w_busy;
  logic             w_expire;
  logic [WIDTH-1:0] w_data_base;
  logic [WIDTH-1:0] w_mask_base;
  logic [31:0]      w_rd;
  logic             w_unused_wd;

  assign w_wr        = chipselect && !write_n;
  assign w_wd        = writedata[WIDTH-1:0];
  assign w_unused_wd = ^writedata;
  assign w_pulse_go  = w_wr && (address == ADDR_PULSE) && (r_plen != '0) && (w_wd != '0);

  // Expiry is applied first so a same-edge write lands on the cleared value.
  assign w_data_base = w_expire ? (r_data_out & ~r_mask) : r_data_out;
  assign w_mask_base = w_expire ? '0 : r_mask;

  pio_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_pulse_go),
    .i_load_val (r_plen),
    .o_busy     (w_busy),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= RESET_VALUE;
      r_mask     <= '0;
      r_plen     <= '0;
    end else begin
      r_data_out <= w_data_base;
      r_mask     <= w_mask_base;
      if (w_wr) begin
        case (address)
          ADDR_DATA: r_data_out <= w_wd;
          ADDR_SET:  r_data_out <= w_data_base | w_wd;
          ADDR_CLR:  r_data_out <= w_data_base & ~w_wd;
          ADDR_PLEN: r_plen     <= writedata[CNT_W-1:0];
          ADDR_PULSE: begin
            if (w_pulse_go) begin
              r_data_out <= w_data_base | w_wd;
              r_mask     <= w_mask_base | w_wd;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      ADDR_DATA:   w_rd[WIDTH-1:0]       = r_data_out;
      ADDR_PLEN:   w_rd[CNT_W-1:0]       = r_plen;
      ADDR_PULSE:  w_rd[WIDTH-1:0]       = r_mask;
      ADDR_STATUS: w_rd[STATUS_BUSY_BIT] = w_busy;
      default:     w_rd                  = '0;
    endcase
  end

  assign readdata = w_rd;
  assign out_port = r_data_out;
endmodule

// File: tb/tb_pio_out_pulse.sv
// Directed self-checking bench for pio_out_pulse at WIDTH=8, CNT_W=16.
module tb_pio_out_pulse;
  localparam logic [2:0] A_DATA = 3'd0, A_SET = 3'd1, A_CLR = 3'd2, A_PLEN = 3'd3,
                         A_PULSE = 3'd4, A_STATUS = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_checks = 0;
  int n_fail   = 0;

  pio_out_pulse #(.WIDTH(8), .CNT_W(16), .RESET_VALUE(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // One bus write; returns 1 time unit after the edge that commits it.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    n_checks++;
    if (out_port !== 8'h00) begin n_fail++; $display("FAIL reset_out got %h want 00", out_port); end
    rd(A_DATA, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", v); end
    rd(A_STATUS, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_status got %h want 0", v); end
    rd(A_PLEN, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_plen got %h want 0", v); end
  endtask

  task automatic test_basic_regs();
    logic [31:0] v;
    wr(A_DATA, 32'hFFFF_FFA5); n_checks++;
    if (out_port !== 8'hA5) begin n_fail++; $display("FAIL data_write got %h want a5", out_port); end
    rd(A_DATA, v); n_checks++;
    if (v !== 32'h0000_00A5) begin n_fail++; $display("FAIL data_read got %h want a5", v); end
    wr(A_SET, 32'h0A); n_checks++;
    if (out_port !== 8'hAF) begin n_fail++; $display("FAIL set_write got %h want af", out_port); end
    rd(A_SET, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL set_read got %h want 0", v); end
    wr(A_CLR, 32'h81); n_checks++;
    if (out_port !== 8'h2E) begin n_fail++; $display("FAIL clr_write got %h want 2e", out_port); end
    wr(A_STATUS, 32'hFF); n_checks++;
    if (out_port !== 8'h2E) begin n_fail++; $display("FAIL status_wr_ignored got %h want 2e", out_port); end
    wr(3'd6, 32'hFF); rd(3'd6, v); n_checks++;
    if (v !== 32'h0 || out_port !== 8'h2E) begin n_fail++; $display("FAIL addr6 got rd=%h out=%h want 0/2e", v, out_port); end
  endtask

  task automatic test_pulse_length();
    logic [31:0] v;
    wr(A_DATA, 32'h0);
    wr(A_PLEN, 32'hABCD_0005);
    rd(A_PLEN, v); n_checks++;
    if (v !== 32'h5) begin n_fail++; $display("FAIL plen_read got %h want 5", v); end
    wr(A_PULSE, 32'h03);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_port !== 8'h03) begin n_fail++; $display("FAIL pulse_high cyc%0d got %h want 03", i, out_port); end
      rd(A_STATUS, v); n_checks++;
      if (v !== 32'h1) begin n_fail++; $display("FAIL pulse_busy cyc%0d got %h want 1", i, v); end
      rd(A_PULSE, v); n_checks++;
      if (v !== 32'h3) begin n_fail++; $display("FAIL pulse_mask cyc%0d got %h want 3", i, v); end
      step();
    end
    n_checks++;
    if (out_port !== 8'h00) begin n_fail++; $display("FAIL pulse_end got %h want 00", out_port); end
    rd(A_STATUS, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL pulse_idle got %h want 0", v); end
    rd(A_PULSE, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL pulse_mask_end got %h want 0", v); end
  endtask

  task automatic test_retrigger();
    int hi0;
    wr(A_DATA, 32'h0);
    wr(A_PLEN, 32'd4);
    wr(A_PULSE, 32'h01);
    hi0 = 1;
    step();
    hi0 += out_port[0];
    wr(A_PULSE, 32'h10);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_port !== 8'h11) begin n_fail++; $display("FAIL retrig_high cyc%0d got %h want 11", i, out_port); end
      hi0 += out_port[0];
      step();
    end
    n_checks++;
    if (out_port !== 8'h00) begin n_fail++; $display("FAIL retrig_fall got %h want 00", out_port); end
    n_checks++;
    if (hi0 !== 6) begin n_fail++; $display("FAIL retrig_bit0_len got %0d want 6", hi0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    wr(A_DATA, 32'h0);
    wr(A_PLEN, 32'd3);
    wr(A_PULSE, 32'h01);
    step(); step();
    wr(A_DATA, 32'hFF);
    n_checks++;
    if (out_port !== 8'hFF) begin n_fail++; $display("FAIL coll_data got %h want ff", out_port); end
    rd(A_STATUS, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL coll_data_busy got %h want 0", v); end
    step(); n_checks++;
    if (out_port !== 8'hFF) begin n_fail++; $display("FAIL coll_data_hold got %h want ff", out_port); end

    wr(A_DATA, 32'h0);
    wr(A_PULSE, 32'h01);
    step(); step();
    wr(A_PULSE, 32'h02);
    n_checks++;
    if (out_port !== 8'h02) begin n_fail++; $display("FAIL coll_retrig_out got %h want 02", out_port); end
    rd(A_PULSE, v); n_checks++;
    if (v !== 32'h2) begin n_fail++; $display("FAIL coll_retrig_mask got %h want 2", v); end
    rd(A_STATUS, v); n_checks++;
    if (v !== 32'h1) begin n_fail++; $display("FAIL coll_retrig_busy got %h want 1", v); end
    step(); step(); n_checks++;
    if (out_port !== 8'h02) begin n_fail++; $display("FAIL coll_retrig_len got %h want 02", out_port); end
    step(); n_checks++;
    if (out_port !== 8'h00) begin n_fail++; $display("FAIL coll_retrig_end got %h want 00", out_port); end
  endtask

  task automatic test_ignore();
    logic [31:0] v;
    wr(A_DATA, 32'h40);
    wr(A_PLEN, 32'd0);
    wr(A_PULSE, 32'h01);
    rd(A_STATUS, v); n_checks++;
    if (out_port !== 8'h40 || v !== 32'h0) begin n_fail++; $display("FAIL ign_plen0 got out=%h busy=%h want 40/0", out_port, v); end
    wr(A_PLEN, 32'd5);
    wr(A_PULSE, 32'h100);
    rd(A_STATUS, v); n_checks++;
    if (out_port !== 8'h40 || v !== 32'h0) begin n_fail++; $display("FAIL ign_wide got out=%h busy=%h want 40/0", out_port, v); end
    rd(A_PULSE, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL ign_mask got %h want 0", v); end
  endtask

  task automatic test_reset_mid_pulse();
    logic [31:0] v;
    int changes;
    logic [7:0] prev;
    wr(A_DATA, 32'h0);
    wr(A_PLEN, 32'd10);
    wr(A_PULSE, 32'h0F);
    step(); step();
    @(negedge clk);
    reset      = 1'b1;
    address    = A_DATA;
    writedata  = 32'h55;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    n_checks++;
    if (out_port !== 8'h00) begin n_fail++; $display("FAIL rst_mid_out got %h want 00", out_port); end
    rd(A_STATUS, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL rst_mid_busy got %h want 0", v); end
    changes = 0;
    prev = out_port;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_port !== prev) changes++;
      prev = out_port;
    end
    n_checks++;
    if (changes !== 0 || out_port !== 8'h00) begin n_fail++; $display("FAIL rst_mid_quiet got changes=%0d out=%h want 0/00", changes, out_port); end
  endtask

  initial begin
    test_reset();
    test_basic_regs();
    test_pulse_length();
    test_retrigger();
    test_back_to_back();
    test_ignore();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
